rv_decode_stage: RTL and testbench

Registered RISC-V instruction decode stage. It accepts a fetched 32-bit instruction and its PC over a valid/ready handshake. It classifies the major opcode (instr[6:2]), extracts the register and function fields, builds the sign-extended immediate for the instruction format, and flags illegal encodings. It sits between fetch and execute in the core and replaces the earlier combinational opcode lookup. Additions over that lookup: configurable XLEN, an optional M extension, backpressure, flush, and an illegal-instruction counter.

---
 rtl/rv_decode_stage_if.sv | 38 +++
 rtl/rv_decode_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// Handshake and decoded-entry bundle for rv_decode_stage.
//   master: upstream fetch / downstream execute side (drives instruction in, out_ready)
//   slave : the decode stage (drives in_ready and all out_* fields)
// Ports: in_valid/in_ready/in_instr/in_pc on the fetch side; out_valid/out_ready plus the
// registered decode fields (pc, opcode, class, rd, rs1, rs2, funct3, funct7, imm, illegal).
interface rv_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_opcode;
  logic [3:0]      out_class;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_class, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_class, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RISC-V decode stage between fetch and execute.
// Classifies the major opcode, extracts register/function fields, builds the sign-extended
// immediate and flags illegal encodings; results appear one cycle after the handshake.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   flush         drop the held entry and refuse input this cycle
//   bus           rv_decode_stage_if.slave: instruction in, decoded entry out
//   illegal_count saturating count of illegal instructions captured
module rv_decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  rv_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] illegal_count
);

  localparam bit Rv64 = (XLEN == 64);

  typedef enum logic [3:0] {
    ClsIllegal = 4'd0,
    ClsLoad    = 4'd1,
    ClsMiscMem = 4'd2,
    ClsOpImm   = 4'd3,
    ClsAuipc   = 4'd4,
    ClsStore   = 4'd5,
    ClsOp      = 4'd6,
    ClsLui     = 4'd7,
    ClsBranch  = 4'd8,
    ClsJalr    = 4'd9,
    ClsJal     = 4'd10,
    ClsSystem  = 4'd11,
    ClsOpImm32 = 4'd12,
    ClsOp32    = 4'd13
  } cls_e;

  typedef enum logic [2:0] {FmtZero, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

  logic [31:0] instr;
  logic [4:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:2];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Shift-immediate upper bits: bit 25 is shamt[5] on RV64, so it is excluded there.
  logic sll_ok, srl_ok, op_ok;
  always_comb begin
    sll_ok = 1'b0;
    srl_ok = 1'b0;
    if (Rv64) begin
      sll_ok = (instr[31:26] == 6'b000000);
      srl_ok = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
    end else begin
      sll_ok = (f7 == 7'b0000000);
      srl_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
    end
  end

  // funct7=0100000 is only SUB/SRA; 0000001 is the M extension.
  assign op_ok = (f7 == 7'b0000000) ||
                 ((f7 == 7'b0100000) && ((f3 == 3'd0) || (f3 == 3'd5))) ||
                 (ENABLE_M && (f7 == 7'b0000001));

  cls_e dec_class;
  fmt_e dec_fmt;
  logic dec_legal;

  always_comb begin
    dec_class = ClsIllegal;
    dec_fmt   = FmtZero;
    dec_legal = 1'b0;
    case (opcode)
      5'b00000: begin
        dec_class = ClsLoad;
        dec_fmt   = FmtI;
        dec_legal = Rv64 ? (f3 != 3'd7) : !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
      end
      5'b00011: begin
        dec_class = ClsMiscMem;
        dec_legal = 1'b1;
      end
      5'b00100: begin
        dec_class = ClsOpImm;
        dec_fmt   = FmtI;
        dec_legal = (f3 == 3'd1) ? sll_ok : ((f3 == 3'd5) ? srl_ok : 1'b1);
      end
      5'b00101: begin
        dec_class = ClsAuipc;
        dec_fmt   = FmtU;
        dec_legal = 1'b1;
      end
      5'b00110: begin
        dec_class = ClsOpImm32;
        dec_fmt   = FmtI;
        dec_legal = Rv64;
      end
      5'b01000: begin
        dec_class = ClsStore;
        dec_fmt   = FmtS;
        dec_legal = Rv64 ? (f3 <= 3'd3) : (f3 <= 3'd2);
      end
      5'b01100: begin
        dec_class = ClsOp;
        dec_legal = op_ok;
      end
      5'b01101: begin
        dec_class = ClsLui;
        dec_fmt   = FmtU;
        dec_legal = 1'b1;
      end
      5'b01110: begin
        dec_class = ClsOp32;
        dec_legal = Rv64 && op_ok;
      end
      5'b11000: begin
        dec_class = ClsBranch;
        dec_fmt   = FmtB;
        dec_legal = (f3 != 3'd2) && (f3 != 3'd3);
      end
      5'b11001: begin
        dec_class = ClsJalr;
        dec_fmt   = FmtI;
        dec_legal = (f3 == 3'd0);
      end
      5'b11011: begin
        dec_class = ClsJal;
        dec_fmt   = FmtJ;
        dec_legal = 1'b1;
      end
      5'b11100: begin
        dec_class = ClsSystem;
        dec_fmt   = FmtI;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    // Compressed encodings are not supported.
    if (instr[1:0] != 2'b11) dec_legal = 1'b0;
    if (!dec_legal) begin
      dec_class = ClsIllegal;
      dec_fmt   = FmtZero;
    end
  end

  // Signed size casts sign-extend each raw immediate straight to XLEN.
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, dec_imm;
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FmtI:    dec_imm = imm_i;
      FmtS:    dec_imm = imm_s;
      FmtB:    dec_imm = imm_b;
      FmtU:    dec_imm = imm_u;
      FmtJ:    dec_imm = imm_j;
      default: dec_imm = '0;
    endcase
  end

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:2]     instr_q;
  cls_e            class_q;
  logic [XLEN-1:0] imm_q;
  logic            illegal_q;
  logic [CNT_W-1:0] count_q;
  logic            ready;
  logic            capture;

  assign ready   = !flush && (!valid_q || bus.out_ready);
  assign capture = bus.in_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      class_q   <= ClsIllegal;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (capture) begin
      valid_q   <= 1'b1;
      pc_q      <= bus.in_pc;
      instr_q   <= instr[31:2];
      class_q   <= dec_class;
      imm_q     <= dec_imm;
      illegal_q <= !dec_legal;
      if (!dec_legal && (count_q != '1)) count_q <= count_q + CNT_W'(1);
    end else if (flush || bus.out_ready) begin
      // Flush or drain; data registers keep their stale contents.
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_opcode  = instr_q[6:2];
  assign bus.out_class   = class_q;
  assign bus.out_rd      = instr_q[11:7];
  assign bus.out_rs1     = instr_q[19:15];
  assign bus.out_rs2     = instr_q[24:20];
  assign bus.out_funct3  = instr_q[14:12];
  assign bus.out_funct7  = instr_q[31:25];
  assign bus.out_imm     = imm_q;
  assign bus.out_illegal = illegal_q;
  assign illegal_count   = count_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Drives three decode stages in lockstep (RV32+M/CNT16, RV32 no M/CNT2, RV64+M/CNT16) and
// checks them against constant vectors and a behavioural reference decoder.
module tb_rv_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  rv_decode_stage_if #(.XLEN(32)) ia ();
  rv_decode_stage_if #(.XLEN(32)) ib ();
  rv_decode_stage_if #(.XLEN(64)) ic ();

  assign ia.in_valid = in_valid;
  assign ib.in_valid = in_valid;
  assign ic.in_valid = in_valid;
  assign ia.in_instr = instr;
  assign ib.in_instr = instr;
  assign ic.in_instr = instr;
  assign ia.in_pc = pc[31:0];
  assign ib.in_pc = pc[31:0];
  assign ic.in_pc = pc;
  assign ia.out_ready = out_ready;
  assign ib.out_ready = out_ready;
  assign ic.out_ready = out_ready;

  logic [15:0] cnt_a, cnt_c;
  logic [1:0]  cnt_b;

  rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(ia), .illegal_count(cnt_a)
  );
  rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(ib), .illegal_count(cnt_b)
  );
  rv_decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .bus(ic), .illegal_count(cnt_c)
  );

  // Uniform views of the three DUTs.
  logic        d_rdy [3];
  logic        d_vld [3];
  logic        d_ill [3];
  logic [3:0]  d_cls [3];
  logic [63:0] d_imm [3];
  logic [63:0] d_pc  [3];
  logic [29:0] d_fld [3];
  logic [15:0] d_cnt [3];

  assign d_rdy[0] = ia.in_ready;
  assign d_rdy[1] = ib.in_ready;
  assign d_rdy[2] = ic.in_ready;
  assign d_vld[0] = ia.out_valid;
  assign d_vld[1] = ib.out_valid;
  assign d_vld[2] = ic.out_valid;
  assign d_ill[0] = ia.out_illegal;
  assign d_ill[1] = ib.out_illegal;
  assign d_ill[2] = ic.out_illegal;
  assign d_cls[0] = ia.out_class;
  assign d_cls[1] = ib.out_class;
  assign d_cls[2] = ic.out_class;
  assign d_imm[0] = {32'b0, ia.out_imm};
  assign d_imm[1] = {32'b0, ib.out_imm};
  assign d_imm[2] = ic.out_imm;
  assign d_pc[0]  = {32'b0, ia.out_pc};
  assign d_pc[1]  = {32'b0, ib.out_pc};
  assign d_pc[2]  = ic.out_pc;
  assign d_fld[0] = {ia.out_funct7, ia.out_funct3, ia.out_rs2, ia.out_rs1, ia.out_rd, ia.out_opcode};
  assign d_fld[1] = {ib.out_funct7, ib.out_funct3, ib.out_rs2, ib.out_rs1, ib.out_rd, ib.out_opcode};
  assign d_fld[2] = {ic.out_funct7, ic.out_funct3, ic.out_rs2, ic.out_rs1, ic.out_rd, ic.out_opcode};
  assign d_cnt[0] = cnt_a;
  assign d_cnt[1] = {14'b0, cnt_b};
  assign d_cnt[2] = cnt_c;

  bit cfg_x64 [3] = '{1'b0, 1'b0, 1'b1};
  bit cfg_m   [3] = '{1'b1, 1'b0, 1'b1};
  int cnt_max [3] = '{65535, 3, 65535};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  // Reference decoder straight from the encoding rules; class 0 means illegal.
  function automatic void ref_dec(input logic [31:0] i, input bit x64, input bit m,
                                  output int cls, output logic [63:0] imm);
    int f3, f7, op, hi;
    bit op_ok, sh_ok;
    longint si, v;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    op = int'(i[6:2]);
    hi = x64 ? int'(i[31:26]) : f7;
    si = longint'($signed(i));
    op_ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (m && f7 == 1);
    sh_ok = (f3 == 1) ? (hi == 0) : (f3 == 5) ? (hi == 0 || hi == (x64 ? 16 : 32)) : 1'b1;
    cls = 0;
    v = 0;
    if (i[1:0] == 2'b11) begin
      case (op)
        0:  if (x64 ? f3 != 7 : !(f3 == 3 || f3 == 6 || f3 == 7)) begin cls = 1; v = si >>> 20; end
        3:  cls = 2;
        4:  if (sh_ok) begin cls = 3; v = si >>> 20; end
        5:  begin cls = 4; v = si & ~longint'(4095); end
        6:  if (x64) begin cls = 12; v = si >>> 20; end
        8:  if (f3 <= (x64 ? 3 : 2)) begin
              cls = 5;
              v = ((si >>> 25) <<< 5) | longint'(i[11:7]);
            end
        12: if (op_ok) cls = 6;
        13: begin cls = 7; v = si & ~longint'(4095); end
        14: if (x64 && op_ok) cls = 13;
        24: if (f3 != 2 && f3 != 3) begin
              cls = 8;
              v = ((si >>> 31) <<< 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5) |
                  (longint'(i[11:8]) << 1);
            end
        25: if (f3 == 0) begin cls = 9; v = si >>> 20; end
        27: begin
              cls = 10;
              v = ((si >>> 31) <<< 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11) |
                  (longint'(i[30:21]) << 1);
            end
        28: begin cls = 11; v = si >>> 20; end
        default: cls = 0;
      endcase
    end
    imm = v;
    if (!x64) imm[63:32] = 32'b0;
  endfunction

  function automatic logic [29:0] fields(input logic [31:0] i);
    return {i[31:25], i[14:12], i[24:20], i[19:15], i[11:7], i[6:2]};
  endfunction

  // Transaction-level model of the stage.
  bit          m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  int          m_cnt [3];

  task automatic check_outputs();
    int cls;
    logic [63:0] imm;
    for (int k = 0; k < 3; k++) begin
      chk("out_valid", k, 64'(d_vld[k]), 64'(m_valid));
      chk("illegal_count", k, 64'(d_cnt[k]), 64'(m_cnt[k]));
      if (m_valid) begin
        ref_dec(m_instr, cfg_x64[k], cfg_m[k], cls, imm);
        chk("class", k, 64'(d_cls[k]), 64'(cls));
        chk("imm", k, d_imm[k], imm);
        chk("illegal", k, 64'(d_ill[k]), 64'(cls == 0));
        chk("fields", k, 64'(d_fld[k]), 64'(fields(m_instr)));
        chk("pc", k, d_pc[k], cfg_x64[k] ? m_pc : {32'b0, m_pc[31:0]});
      end
    end
  endtask

  task automatic tick();
    bit rdy;
    int cls;
    logic [63:0] imm;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    for (int k = 0; k < 3; k++) chk("in_ready", k, 64'(d_rdy[k]), 64'(rdy));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    end else if (in_valid && rdy) begin
      m_valid = 1'b1;
      m_instr = instr;
      m_pc    = pc;
      for (int k = 0; k < 3; k++) begin
        ref_dec(instr, cfg_x64[k], cfg_m[k], cls, imm);
        if (cls == 0 && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      end
    end else if (flush || out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  typedef struct {
    logic [31:0] instr;
    int          cls_a;
    int          cls_b;
    int          cls_c;
    logic [63:0] imm_c;
  } vec_t;

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  ops [14];
    ops = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd12, 5'd13, 5'd14, 5'd24, 5'd25, 5'd27,
            5'd28, 5'd31};
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[6:2] = ops[$urandom_range(0, 13)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 9) != 0) r[1:0] = 2'b11;
    return r;
  endfunction

  initial begin
    vec_t vecs [18];
    int   cls_exp [3];
    logic [63:0] imm_exp, held_pc;
    logic [15:0] seq_b [5];
    int   cnt_hold [3];

    vecs = '{
      '{32'h00500093, 3, 3, 3, 64'd5},
      '{32'hFE000EE3, 8, 8, 8, 64'hFFFF_FFFF_FFFF_FFFC},
      '{32'h123450B7, 7, 7, 7, 64'h0000_0000_1234_5000},
      '{32'h02208033, 6, 0, 6, 64'd0},
      '{32'h00000001, 0, 0, 0, 64'd0},
      '{32'h0000B083, 0, 0, 1, 64'd0},
      '{32'h0000003B, 0, 0, 13, 64'd0},
      '{32'h02009093, 0, 0, 3, 64'd32},
      '{32'h4010D093, 3, 3, 3, 64'h401},
      '{32'h40208033, 6, 6, 6, 64'd0},
      '{32'h40209033, 0, 0, 0, 64'd0},
      '{32'hFFDFF0EF, 10, 10, 10, 64'hFFFF_FFFF_FFFF_FFFC},
      '{32'h0010A223, 5, 5, 5, 64'd4},
      '{32'h000090E7, 0, 0, 0, 64'd0},
      '{32'hFFFFF097, 4, 4, 4, 64'hFFFF_FFFF_FFFF_F000},
      '{32'h0010B023, 0, 0, 5, 64'd0},
      '{32'h00000073, 11, 11, 11, 64'd0},
      '{32'h0000000F, 2, 2, 2, 64'd0}
    };
    seq_b = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
    m_valid = 1'b0; m_instr = '0; m_pc = '0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 64'(d_vld[k]), 64'd0);
      chk("rst_class", k, 64'(d_cls[k]), 64'd0);
      chk("rst_imm", k, d_imm[k], 64'd0);
      chk("rst_pc", k, d_pc[k], 64'd0);
      chk("rst_fields", k, 64'(d_fld[k]), 64'd0);
      chk("rst_illegal", k, 64'(d_ill[k]), 64'd0);
      chk("rst_count", k, 64'(d_cnt[k]), 64'd0);
      chk("rst_ready", k, 64'(d_rdy[k]), 64'd1);
    end

    // Counter saturation on CNT_W=2, then reset mid-stream.
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00000001; pc = 64'h100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cnt_seq_b", 1, 64'(d_cnt[1]), 64'(seq_b[i]));
      chk("cnt_seq_a", 0, 64'(d_cnt[0]), 64'(i + 1));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_valid", k, 64'(d_vld[k]), 64'd0);
      chk("midrst_count", k, 64'(d_cnt[k]), 64'd0);
    end

    // Constant vectors, streamed back to back.
    for (int v = 0; v < 18; v++) begin
      instr = vecs[v].instr;
      pc = 64'h8000_0000_0000_1000 + 64'(4 * v);
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
      tick();
      cls_exp = '{vecs[v].cls_a, vecs[v].cls_b, vecs[v].cls_c};
      for (int k = 0; k < 3; k++) begin
        if (k == 2) imm_exp = vecs[v].imm_c;
        else imm_exp = (cls_exp[k] != 0) ? {32'b0, vecs[v].imm_c[31:0]} : 64'd0;
        chk("vec_class", k, 64'(d_cls[k]), 64'(cls_exp[k]));
        chk("vec_imm", k, d_imm[k], imm_exp);
        chk("vec_illegal", k, 64'(d_ill[k]), 64'(cls_exp[k] == 0));
        chk("vec_valid", k, 64'(d_vld[k]), 64'd1);
      end
    end
    in_valid = 1'b0;
    tick();

    // Backpressure for three cycles, then flush with a pending illegal input.
    instr = 32'h00500093; pc = 64'h2000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    held_pc = 64'h2000;
    out_ready = 1'b0; instr = 32'h00000001; pc = 64'h3000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_ready", 0, 64'(d_rdy[0]), 64'd0);
      chk("stall_valid", 0, 64'(d_vld[0]), 64'd1);
      chk("stall_pc", 0, d_pc[0], held_pc);
      chk("stall_class", 0, 64'(d_cls[0]), 64'd3);
    end
    for (int k = 0; k < 3; k++) cnt_hold[k] = int'(d_cnt[k]);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush_valid", k, 64'(d_vld[k]), 64'd0);
      chk("flush_count", k, 64'(d_cnt[k]), 64'(cnt_hold[k]));
    end
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      instr     = rand_instr();
      pc        = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
